// File: rtl/uart_rx_core.sv
// UART receive engine: rx synchroniser, 3-sample majority voting,
// runtime data length / parity / stop-bit count, break detection and
// a valid/ready output stage with sticky overrun reporting.
module uart_rx_core #(
  parameter int DATA_MAX    = 9,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_W       = $clog2(OVERSAMPLE),
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                rx,
  input  logic [3:0]          cfg_data_bits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun
);

  localparam int M = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] C_S0  = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] C_S1  = CNT_W'(M);
  localparam logic [CNT_W-1:0] C_S2  = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       C_DMAX = 4'(DATA_MAX);
  localparam logic [3:0]       C_DMIN = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_WAIT_HIGH
  } state_t;

  // synchroniser and sampling
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic                   w_vote;
  logic                   w_at_s2;
  logic                   w_at_end;

  // FSM and frame datapath
  state_t                 r_state;
  state_t                 w_nstate;
  logic [3:0]             w_nbits;
  logic [3:0]             r_nbits;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_stop2;
  logic [3:0]             r_bitcnt;
  logic [DATA_MAX-1:0]    r_shift;
  logic                   r_pbit;

  // FSM control strobes (only ever asserted on a sample_tick)
  logic                   w_cnt_clr;
  logic                   w_enter_start;
  logic                   w_store_bit;
  logic                   w_bit_adv;
  logic                   w_store_pbit;
  logic                   w_done;
  logic                   w_stop_bad;
  logic                   w_perr;
  logic                   w_brk;
  logic                   w_hs;

  // output holding registers
  logic [DATA_MAX-1:0]    r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_brk;
  logic                   r_ovr;

  // rx synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  assign w_rxs    = r_sync[SYNC_STAGES-1];
  assign w_at_s2  = (r_cnt == C_S2);
  assign w_at_end = (r_cnt == C_END);
  // third sample is the live synchronised value at cnt = M+1
  assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

  // clamp the requested data length into 5..DATA_MAX
  always_comb begin
    w_nbits = cfg_data_bits;
    if (cfg_data_bits < C_DMIN)      w_nbits = C_DMIN;
    else if (cfg_data_bits > C_DMAX) w_nbits = C_DMAX;
  end

  // oversampling counter and the first two majority samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else if (sample_tick) begin
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_state != S_IDLE && r_state != S_WAIT_HIGH)
        r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == C_S0) r_s0 <= w_rxs;
      if (r_cnt == C_S1) r_s1 <= w_rxs;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  // FSM next-state and control strobes
  always_comb begin
    w_nstate      = r_state;
    w_cnt_clr     = 1'b0;
    w_enter_start = 1'b0;
    w_store_bit   = 1'b0;
    w_bit_adv     = 1'b0;
    w_store_pbit  = 1'b0;
    w_done        = 1'b0;
    w_stop_bad    = 1'b0;
    if (sample_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_nstate      = S_START;
            w_cnt_clr     = 1'b1;
            w_enter_start = 1'b1;
          end
        end
        S_START: begin
          if (w_at_s2 && w_vote) begin
            // glitch, not a real start bit
            w_nstate  = S_IDLE;
            w_cnt_clr = 1'b1;
          end else if (w_at_end) begin
            w_nstate  = S_DATA;
            w_cnt_clr = 1'b1;
          end
        end
        S_DATA: begin
          if (w_at_s2) w_store_bit = 1'b1;
          if (w_at_end) begin
            w_cnt_clr = 1'b1;
            if (r_bitcnt == r_nbits - 4'd1)
              w_nstate = r_par_en ? S_PARITY : S_STOP1;
            else
              w_bit_adv = 1'b1;
          end
        end
        S_PARITY: begin
          if (w_at_s2) w_store_pbit = 1'b1;
          if (w_at_end) begin
            w_nstate  = S_STOP1;
            w_cnt_clr = 1'b1;
          end
        end
        S_STOP1: begin
          // decide mid-bit; a good first stop with two stops configured
          // runs to bit end so the second stop is sampled at its centre
          if (w_at_s2) begin
            if (!w_vote) begin
              w_done     = 1'b1;
              w_stop_bad = 1'b1;
              w_nstate   = S_WAIT_HIGH;
              w_cnt_clr  = 1'b1;
            end else if (!r_stop2) begin
              w_done    = 1'b1;
              w_nstate  = S_IDLE;
              w_cnt_clr = 1'b1;
            end
          end else if (w_at_end && r_stop2) begin
            w_nstate  = S_STOP2;
            w_cnt_clr = 1'b1;
          end
        end
        S_STOP2: begin
          if (w_at_s2) begin
            w_done     = 1'b1;
            w_cnt_clr  = 1'b1;
            w_stop_bad = !w_vote;
            w_nstate   = w_vote ? S_IDLE : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (w_rxs) begin
            w_nstate  = S_IDLE;
            w_cnt_clr = 1'b1;
          end
        end
        default: begin
          w_nstate  = S_IDLE;
          w_cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // frame datapath: config latch, data shifter, parity bit capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nbits   <= C_DMIN;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_stop2   <= 1'b0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_pbit    <= 1'b0;
    end else begin
      if (w_enter_start) begin
        r_nbits   <= w_nbits;
        r_par_en  <= cfg_parity[0] ^ cfg_parity[1];
        r_par_odd <= cfg_parity[1] & ~cfg_parity[0];
        r_stop2   <= cfg_stop2;
        r_bitcnt  <= '0;
        r_shift   <= '0;
        r_pbit    <= 1'b0;
      end
      // LSB arrives first; writing by index keeps the word right-justified
      if (w_store_bit)  r_shift  <= r_shift | (DATA_MAX'(w_vote) << r_bitcnt);
      if (w_bit_adv)    r_bitcnt <= r_bitcnt + 4'd1;
      if (w_store_pbit) r_pbit   <= w_vote;
    end
  end

  // unused high bits of r_shift are zero, so a full-width XOR is exact
  assign w_perr = r_par_en & ((^r_shift) ^ r_pbit ^ r_par_odd);
  assign w_brk  = w_stop_bad & (r_shift == '0) & (~r_par_en | ~r_pbit);
  assign w_hs   = r_valid & rx_ready;

  // output stage: load on completion unless a word is held and not taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_hs) r_ovr <= 1'b0;
      if (w_done && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_perr  <= w_perr;
        r_ferr  <= w_stop_bad;
        r_brk   <= w_brk;
        r_valid <= 1'b1;
      end else if (w_done) begin
        r_ovr <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign break_det  = r_brk;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are bit-banged on rx with a
// sample_tick every clk; expected words go into a scoreboard queue when
// sent and are popped when the DUT presents them.
module tb_uart_rx_core;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t_rise   = 0;
  logic prev_v   = 1'b0;
  int   t0;

  uart_rx_core dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .rx            (rx),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .break_det     (break_det),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // timestamp (posedge count) of each rx_valid rise
  always @(negedge clk) begin
    if (rx_valid && !prev_v) t_rise <= cyc;
    prev_v <= rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one bit time; caller sits just after a negedge. The DUT samples
  // cnt = M at bit offset M+1 (two sync flops plus the IDLE detect tick).
  task automatic send_bit(input logic v, input int glitch);
    for (int i = 0; i < OS; i++) begin
      rx = (i == glitch) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // par: 0 none, 1 even, 2 odd
  task automatic send_frame(input logic [8:0] d, input int nb, input int par,
                            input bit pflip, input int nstop, input logic st1,
                            input logic st2, input int gbit, input bit scramble,
                            input bit push, output int ts);
    logic       pb;
    exp_t       e;
    logic [3:0] sv_bits;
    logic [1:0] sv_par;
    logic       sv_st2;
    pb   = ((par == 2) ? ~(^d) : (^d)) ^ pflip;
    e.d  = d;
    e.pe = (par != 0) && pflip;
    e.fe = !st1 || (nstop == 2 && !st2);
    e.bk = e.fe && (d == 9'd0) && (par == 0 || !pb);
    if (push) sb.push_back(e);
    sv_bits = cfg_data_bits;
    sv_par  = cfg_parity;
    sv_st2  = cfg_stop2;
    ts = cyc + 1;
    send_bit(1'b0, -1);
    if (scramble) begin
      cfg_data_bits = 4'd6;
      cfg_parity    = 2'b10;
      cfg_stop2     = ~sv_st2;
    end
    for (int b = 0; b < nb; b++) send_bit(d[b], (b == gbit) ? OS/2 + 1 : -1);
    if (par != 0) send_bit(pb, -1);
    send_bit(st1, -1);
    if (nstop == 2) send_bit(st2, -1);
    cfg_data_bits = sv_bits;
    cfg_parity    = sv_par;
    cfg_stop2     = sv_st2;
    idle(2 * OS);
  endtask

  // wait (bounded) for a word, check it against the scoreboard, accept it
  task automatic get_word(input string tag, input logic exp_ovr);
    int   w;
    exp_t e;
    w = 0;
    while (!rx_valid && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".valid"}, {31'd0, rx_valid}, 32'd1);
    chk({tag, ".sb"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (rx_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".data"},  {23'd0, rx_data},    {23'd0, e.d});
      chk({tag, ".perr"},  {31'd0, parity_err}, {31'd0, e.pe});
      chk({tag, ".ferr"},  {31'd0, frame_err},  {31'd0, e.fe});
      chk({tag, ".brk"},   {31'd0, break_det},  {31'd0, e.bk});
      chk({tag, ".ovr"},   {31'd0, overrun},    {31'd0, exp_ovr});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk({tag, ".vclr"},  {31'd0, rx_valid},   32'd0);
      chk({tag, ".oclr"},  {31'd0, overrun},    32'd0);
    end
  endtask

  task automatic expect_none(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (rx_valid) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0; sample_tick = 1'b1;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.data",  {23'd0, rx_data}, 32'd0);
    chk("rst.valid", {31'd0, rx_valid}, 32'd0);
    chk("rst.flags", {28'd0, parity_err, frame_err, break_det, overrun}, 32'd0);
    rst = 1'b0;
    idle(4);

    // 8N1 0xA5; valid rises 2 sync + 1 detect + 9 bit times + (M+1) after P0
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1, t0);
    chk("t1.latency", t_rise - t0, 3 + OS * 9 + OS/2 + 1);
    get_word("t1", 1'b0);

    // 7E1 0x41 with wrong then right parity bit
    cfg_data_bits = 4'd7; cfg_parity = 2'b01;
    send_frame(9'h041, 7, 1, 1'b1, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1, t0);
    get_word("t2a", 1'b0);
    send_frame(9'h041, 7, 1, 1'b0, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1, t0);
    get_word("t2b", 1'b0);

    // length below 5 clamps to 5
    cfg_data_bits = 4'd2; cfg_parity = 2'b00;
    send_frame(9'h015, 5, 0, 1'b0, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1, t0);
    get_word("clamp5", 1'b0);

    // short low pulse is a false start; next frame changes cfg mid-frame
    cfg_data_bits = 4'd8;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    expect_none("t3.false_start", 4 * OS);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 1'b1, 1'b1, t0);
    get_word("t3", 1'b0);

    // break: line low for 20 bit times gives exactly one word
    sb.push_back('{d: 9'd0, pe: 1'b0, fe: 1'b1, bk: 1'b1});
    rx = 1'b0;
    repeat (20 * OS) @(negedge clk);
    idle(2 * OS);
    get_word("t4.brk", 1'b0);
    expect_none("t4.single", 4 * OS);
    send_frame(9'h055, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1, t0);
    get_word("t4.after", 1'b0);

    // overrun: second frame dropped while first is held
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1, t0);
    send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 1'b0, 1'b0, t0);
    get_word("t5", 1'b1);

    // 9O2, length 15 clamps to 9, glitch on bit 3, second stop low
    cfg_data_bits = 4'hF; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    send_frame(9'h1FF, 9, 2, 1'b0, 2, 1'b1, 1'b0, 3, 1'b0, 1'b1, t0);
    get_word("t6", 1'b0);

    // reset mid-frame aborts without output
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    expect_none("rst.abort", 25 * OS);
    chk("sb.empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receive engine: datapath, oversampling counters and control FSM in one block. Supports runtime-selectable data length, parity mode and stop-bit count. Adds 3-sample majority voting, break detection, and a valid/ready output with overrun reporting. Sits between the pad-side rx line and the bus-side receive FIFO; a shared baud generator supplies sample_tick.

Parameters:
DATA_MAX, 9, maximum data bits per frame (5..9)
OVERSAMPLE, 16, sample_ticks per bit (even, >=8)
CNT_W, $clog2(OVERSAMPLE), sampling counter width
SYNC_STAGES, 2, rx synchroniser depth (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
sample_tick  in  1  oversampling enable, one clk wide
rx  in  1  serial line, asynchronous, idle high
cfg_data_bits  in  4  data length; <5 treated as 5, >DATA_MAX treated as DATA_MAX
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  in  1  1 = two stop bits checked
rx_data  out  DATA_MAX  received word, LSB-first on line, right-justified, unused MSBs 0
rx_valid  out  1  word and flags valid
rx_ready  in  1  consumer accepts word when rx_valid=1
parity_err  out  1  parity mismatch for held word
frame_err  out  1  stop bit sampled low for held word
break_det  out  1  held word is a break
overrun  out  1  sticky: a frame was dropped while rx_valid was held

Behaviour:
- Decided: reset rst, asynchronous, active-high; clock clk.
- Reset: synchroniser flops =1, state IDLE, counters 0, all outputs 0. Reset mid-frame aborts the frame; nothing is emitted.
- rx passes through SYNC_STAGES flops; all logic uses the synchronised value (rxs). Counters and sampling advance only on sample_tick.
- Config latch: cfg_* captured on entry to START and held for the frame. Mid-frame cfg changes have no effect.
- Bit timing:
  - Counter cnt is cleared on each state entry and on each bit boundary.
  - Samples are taken at cnt = M-1, M, M+1, where M = OVERSAMPLE/2. Bit value = majority of the three samples.
  - A bit ends at the tick where cnt = OVERSAMPLE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE: rxs=0 on a tick -> START.
  - START: vote=1 -> IDLE (false start, no output). Vote=0 -> DATA at bit end.
  - DATA: shift in the bit; after cfg_data_bits bits -> PARITY if parity is enabled, else STOP1.
  - PARITY: even mode: XOR(data, pbit) must be 0. Odd mode: it must be 1. Mismatch sets parity_err.
  - STOP1: decision at sample M+1 (no wait for bit end). If vote=0 -> frame_err, and WAIT_HIGH. Else -> STOP2 if cfg_stop2, else complete, then IDLE.
  - STOP2: same check as STOP1; then complete.
  - Break: data all 0, pbit 0 (if enabled), and failing stop vote=0 -> break_det=1, frame_err=1.
  - WAIT_HIGH: stay until rxs=1, then IDLE.
- Completion: rx_data and flags load, and rx_valid=1, on the clk edge after the deciding sample_tick. Latency from the deciding tick = 1 clk.
- Handshake:
  - rx_valid, rx_data and flags are held stable until a cycle with rx_valid & rx_ready; rx_valid drops the following cycle.
  - Completion in the same cycle as the handshake: the new word loads, rx_valid stays 1, no overrun.
  - Completion while rx_valid=1 and rx_ready=0: the new word is discarded, the held word is kept, and overrun is set.
  - overrun clears on the next handshake.
- Flags are per-word, not sticky, except overrun.

Test Plan:
1. OVERSAMPLE=16, tick every clk, 8N1, send 0xA5 -> rx_data=0x0A5, rx_valid 1 clk after the tick at stop-bit sample M+1 (cnt 9); all flags 0.
2. 7-bit even parity, send 0x41 with pbit=1 -> rx_data=0x041, parity_err=1, frame_err=0. Repeat with pbit=0 -> parity_err=0.
3. rx low for 4 ticks, then high -> no rx_valid, FSM back in IDLE. Then 8N1 0x3C -> received correctly.
4. 8N1, rx held low for 20 bit times -> one word: rx_data=0, frame_err=1, break_det=1, no further words. rx high, then 0x55 -> single correct word.
5. rx_ready=0, frames 0x11 and 0x22 -> rx_data stays 0x011, overrun=1. Pulse rx_ready -> rx_valid and overrun clear next cycle.
6. 9 data bits, odd parity, cfg_stop2=1, send 0x1FF with one sample inverted at cnt=M in bit 3 and second stop low -> rx_data=0x1FF, parity_err=0, frame_err=1, break_det=0.
